// File: rtl/zl_rs_shortened_ctrl.sv
// Sequencer that runs a full-length RS(N,K) encoder core as a shortened RS(N_SHORT,K_SHORT) code.
// Define ZL_RS_CTRL_SOP_RESYNC_EN to drop symbols until SOP and flag SOP errors on sync_err.
module zl_rs_shortened_ctrl #(
    parameter int unsigned N       = 255,
    parameter int unsigned K       = 239,
    parameter int unsigned M       = 8,
    parameter int unsigned N_SHORT = 204
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         data_in_req,
    output logic         data_in_ack,
    input  logic [M-1:0] data_in,
    input  logic         data_in_sop,
    output logic         enc_in_req,
    input  logic         enc_in_ack,
    output logic [M-1:0] enc_in,
    input  logic         enc_out_req,
    output logic         enc_out_ack,
    input  logic [M-1:0] enc_out,
    output logic         data_out_req,
    input  logic         data_out_ack,
    output logic [M-1:0] data_out,
    output logic         data_out_sop,
    output logic         sync_err
);

    localparam int unsigned Pad    = N - N_SHORT;
    localparam int unsigned KShort = N_SHORT - (N - K);

    localparam logic [M-1:0] PadCnt   = M'(Pad);
    localparam logic [M-1:0] PadLast  = M'(Pad - 1);
    localparam logic [M-1:0] DataLast = M'(Pad + KShort - 1);
    localparam logic [M-1:0] CwLast   = M'(N - 1);

    typedef enum logic [1:0] {StPad, StData, StParity} phase_e;

    // With no padding the codeword starts directly in the data phase.
    localparam phase_e StStart = (Pad != 0) ? StPad : StData;

    phase_e       phase_q, phase_d;
    logic [M-1:0] cnt_q, cnt_d;
    logic         advance;
    logic         fire;

`ifdef ZL_RS_CTRL_SOP_RESYNC_EN
    logic err_set;
    logic sync_err_q;
    logic unused_inputs;
    assign unused_inputs = enc_in_ack;
`else
    logic unused_inputs;
    assign unused_inputs = ^{enc_in_ack, data_in_sop};
`endif

    always_comb begin
        phase_d      = phase_q;
        cnt_d        = cnt_q;
        advance      = 1'b0;
        fire         = 1'b0;
        data_in_ack  = 1'b0;
        enc_in_req   = 1'b0;
        enc_in       = '0;
        enc_out_ack  = 1'b0;
        data_out_req = 1'b0;
        data_out     = enc_out;
        data_out_sop = 1'b0;
`ifdef ZL_RS_CTRL_SOP_RESYNC_EN
        err_set      = 1'b0;
`endif
        unique case (phase_q)
            StPad: begin
                // Zero pad symbols are self-fed; the core output is discarded.
                enc_in_req  = 1'b1;
                enc_out_ack = 1'b1;
                advance     = 1'b1;
            end
            StData: begin
                enc_in       = data_in;
                enc_in_req   = data_in_req;
                fire         = data_in_req & data_out_ack;
                enc_out_ack  = fire;
                data_in_ack  = fire;
                data_out_req = data_in_req & enc_out_req;
                advance      = fire;
`ifdef ZL_RS_CTRL_SOP_RESYNC_EN
                if (cnt_q == PadCnt && data_in_req && !data_in_sop) begin
                    // Drop symbols until a packet start lines up with the first data slot.
                    data_in_ack  = 1'b1;
                    enc_out_ack  = 1'b0;
                    data_out_req = 1'b0;
                    advance      = 1'b0;
                    err_set      = 1'b1;
                end else if (cnt_q != PadCnt && fire && data_in_sop) begin
                    err_set = 1'b1;
                end
`endif
                data_out_sop = (cnt_q == PadCnt) & data_out_req;
            end
            StParity: begin
                enc_in_req   = 1'b1;
                enc_out_ack  = data_out_ack;
                data_out_req = enc_out_req;
                advance      = data_out_ack;
            end
            default: ;
        endcase

        if (advance) begin
            if (cnt_q == CwLast) begin
                cnt_d   = '0;
                phase_d = StStart;
            end else begin
                cnt_d = cnt_q + 1'b1;
                if (phase_q == StPad && cnt_q == PadLast) begin
                    phase_d = StData;
                end else if (phase_q == StData && cnt_q == DataLast) begin
                    phase_d = StParity;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= StStart;
            cnt_q   <= '0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef ZL_RS_CTRL_SOP_RESYNC_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_err_q <= 1'b0;
        end else if (err_set) begin
            sync_err_q <= 1'b1;
        end
    end

    assign sync_err = sync_err_q;
`else
    assign sync_err = 1'b0;
`endif

endmodule

// File: tb/tb_zl_rs_shortened_ctrl.sv
// Scoreboard bench for zl_rs_shortened_ctrl with a behavioural RS(255,239) core and
// a polynomial long-division golden model for the shortened RS(204,188) parity.
module tb_zl_rs_shortened_ctrl;

    localparam int N   = 255;
    localparam int K   = 239;
    localparam int NS  = 204;
    localparam int PAD = 51;
    localparam int KS  = 188;
    localparam int NP  = 16;

    logic       clk;
    logic       rst_n;
    logic       data_in_req;
    logic       data_in_ack;
    logic [7:0] data_in;
    logic       data_in_sop;
    logic       enc_in_req;
    logic       enc_in_ack;
    logic [7:0] enc_in;
    logic       enc_out_req;
    logic       enc_out_ack;
    logic [7:0] enc_out;
    logic       data_out_req;
    logic       data_out_ack;
    logic [7:0] data_out;
    logic       data_out_sop;
    logic       sync_err;

    typedef struct {
        logic [7:0] data;
        logic       sop;
        int         cnt;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] pkt [KS];
    logic [7:0] g [NP];
    int         checks   = 0;
    int         failures = 0;
    logic       stall_en = 1'b0;
    logic       chk_en   = 1'b1;

    zl_rs_shortened_ctrl #(
        .N       (N),
        .K       (K),
        .M       (8),
        .N_SHORT (NS)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .data_in_req  (data_in_req),
        .data_in_ack  (data_in_ack),
        .data_in      (data_in),
        .data_in_sop  (data_in_sop),
        .enc_in_req   (enc_in_req),
        .enc_in_ack   (enc_in_ack),
        .enc_in       (enc_in),
        .enc_out_req  (enc_out_req),
        .enc_out_ack  (enc_out_ack),
        .enc_out      (enc_out),
        .data_out_req (data_out_req),
        .data_out_ack (data_out_ack),
        .data_out     (data_out),
        .data_out_sop (data_out_sop),
        .sync_err     (sync_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1D) : {aa[6:0], 1'b0};
        end
        return p;
    endfunction

    // Behavioural full-length systematic core; advances on every enc_out_ack.
    int         core_cnt;
    logic [7:0] par [NP];
    logic [7:0] fb;

    assign fb          = enc_in ^ par[NP-1];
    assign enc_in_ack  = enc_out_ack;
    assign enc_out_req = (core_cnt < K) ? enc_in_req : 1'b1;
    assign enc_out     = (core_cnt < K) ? enc_in : par[NP-1];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_cnt <= 0;
            for (int i = 0; i < NP; i++) par[i] <= 8'h00;
        end else if (enc_out_ack) begin
            if (core_cnt < K) begin
                for (int i = NP - 1; i > 0; i--) par[i] <= par[i-1] ^ gmul(fb, g[i]);
                par[0] <= gmul(fb, g[0]);
            end else begin
                for (int i = NP - 1; i > 0; i--) par[i] <= par[i-1];
                par[0] <= 8'h00;
            end
            core_cnt <= (core_cnt == N - 1) ? 0 : core_cnt + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Remainder of pkt(x)*x^16 mod g(x) by long division, pushed as a full codeword.
    task automatic push_expected();
        logic [7:0] r [NS];
        logic [7:0] c;
        exp_t       e;
        for (int i = 0; i < NS; i++) r[i] = (i < KS) ? pkt[i] : 8'h00;
        for (int i = 0; i < KS; i++) begin
            c = r[i];
            for (int k = 0; k < NP; k++) r[i+NP-k] = r[i+NP-k] ^ gmul(c, g[k]);
        end
        for (int j = 0; j < NS; j++) begin
            e.data = (j < KS) ? pkt[j] : r[j];
            e.sop  = (j == 0);
            e.cnt  = PAD + j;
            sb.push_back(e);
        end
    endtask

    task automatic push_sym(input logic [7:0] b, input logic sop);
        int   t;
        logic acc;
        logic done;
        t           = 0;
        done        = 1'b0;
        data_in_req = 1'b1;
        data_in     = b;
        data_in_sop = sop;
        while (!done) begin
            @(negedge clk);
            acc = data_in_ack;
            @(posedge clk);
            #1;
            if (acc) begin
                done = 1'b1;
            end else if (++t > 2000) begin
                checks++;
                failures++;
                $display("FAIL in_timeout: symbol %0h not accepted within 2000 cycles", b);
                done = 1'b1;
            end
        end
        data_in_req = 1'b0;
        data_in_sop = 1'b0;
    endtask

    task automatic send_packet(input logic gaps);
        for (int i = 0; i < KS; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
            push_sym(pkt[i], i == 0);
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 3000) begin
            @(posedge clk);
            t++;
        end
        #1;
        check("drain_left", sb.size(), 0);
    endtask

    initial begin
        data_out_ack = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            data_out_ack = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: every downstream transfer must match the next expected symbol.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && chk_en && data_out_req && data_out_ack) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL out_unexpected: data=%0h sop=%0b", data_out, data_out_sop);
                end else begin
                    e = sb.pop_front();
                    if (data_out !== e.data || data_out_sop !== e.sop || core_cnt != e.cnt) begin
                        failures++;
                        $display("FAIL out_sym: got data=%0h sop=%0b core_cnt=%0d expected data=%0h sop=%0b core_cnt=%0d",
                                 data_out, data_out_sop, core_cnt, e.data, e.sop, e.cnt);
                    end
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] gg [NP+1];
        logic [7:0] a;
        for (int k = 0; k <= NP; k++) gg[k] = 8'h00;
        gg[0] = 8'h01;
        a     = 8'h01;
        for (int i = 0; i < NP; i++) begin
            for (int k = NP; k > 0; k--) gg[k] = gg[k-1] ^ gmul(gg[k], a);
            gg[0] = gmul(gg[0], a);
            a     = gmul(a, 8'h02);
        end
        for (int k = 0; k < NP; k++) g[k] = gg[k];

        rst_n       = 1'b0;
        data_in_req = 1'b0;
        data_in     = 8'h00;
        data_in_sop = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_data_out_req", data_out_req, 0);
        check("rst_data_in_ack", data_in_ack, 0);
        check("rst_sync_err", sync_err, 0);
        rst_n = 1'b1;

        // Exactly PAD self-fed cycles, then the controller waits for data.
        for (int i = 0; i < PAD; i++) begin
            @(negedge clk);
            check("pad_cycle", {enc_out_ack, data_in_ack, data_out_req}, 3'b100);
        end
        @(negedge clk);
        check("pad_len", enc_out_ack, 0);
        @(posedge clk);
        #1;

        for (int i = 0; i < KS; i++) pkt[i] = 8'(i);
        push_expected();
        send_packet(1'b0);
        drain();

        for (int i = 0; i < KS; i++) pkt[i] = 8'h00;
        push_expected();
        send_packet(1'b0);
        drain();

        for (int i = 0; i < KS; i++) pkt[i] = 8'(i * 7 + 3);
        push_expected();
        send_packet(1'b0);
        for (int i = 0; i < KS; i++) pkt[i] = 8'hFF ^ 8'(i * 11);
        push_expected();
        send_packet(1'b0);
        drain();

        stall_en = 1'b1;
        for (int i = 0; i < KS; i++) pkt[i] = 8'(i * 13) ^ 8'h5A;
        push_expected();
        send_packet(1'b1);
        drain();
        stall_en = 1'b0;

        // Abort at data symbol 100 with a reset, then send a clean packet.
        chk_en = 1'b0;
        for (int i = 0; i < KS; i++) pkt[i] = 8'(i * 3 + 1);
        for (int i = 0; i < 100; i++) push_sym(pkt[i], i == 0);
        data_in_req = 1'b1;
        data_in     = pkt[100];
        rst_n       = 1'b0;
        #1;
        data_in_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("midrst_data_out_req", data_out_req, 0);
        check("midrst_data_in_ack", data_in_ack, 0);
        sb.delete();
        rst_n  = 1'b1;
        chk_en = 1'b1;
        for (int i = 0; i < KS; i++) pkt[i] = 8'hA5 ^ 8'(i * 5);
        push_expected();
        send_packet(1'b0);
        drain();

`ifdef ZL_RS_CTRL_SOP_RESYNC_EN
        check("sync_err_clear", sync_err, 0);
        for (int i = 0; i < 3; i++) push_sym(8'hE0 + 8'(i), 1'b0);
        @(negedge clk);
        check("sync_err_set", sync_err, 1);
        @(posedge clk);
        #1;
        for (int i = 0; i < KS; i++) pkt[i] = 8'(i * 17 + 9);
        push_expected();
        send_packet(1'b0);
        drain();
        check("sync_err_sticky", sync_err, 1);
`else
        check("sync_err_zero", sync_err, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
